// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants for the 8-bit computer's control sequencer.
//   - bit positions of each control line within the 16-bit control word
//   - single-bit masks built from those positions
//   - opcode encodings of the instruction register's upper nibble
//   - the two fetch words common to every instruction
package ctrl_pkg;

  localparam int unsigned CTRL_W = 16;
  localparam int unsigned STEP_W = 3;

  // Control word bit positions, MSB first.
  localparam int unsigned B_HLT = 15;
  localparam int unsigned B_MI  = 14;
  localparam int unsigned B_RI  = 13;
  localparam int unsigned B_RO  = 12;
  localparam int unsigned B_IO  = 11;
  localparam int unsigned B_II  = 10;
  localparam int unsigned B_AI  = 9;
  localparam int unsigned B_AO  = 8;
  localparam int unsigned B_EO  = 7;
  localparam int unsigned B_SU  = 6;
  localparam int unsigned B_BI  = 5;
  localparam int unsigned B_OI  = 4;
  localparam int unsigned B_CE  = 3;
  localparam int unsigned B_CO  = 2;
  localparam int unsigned B_J   = 1;
  localparam int unsigned B_FI  = 0;

  localparam logic [CTRL_W-1:0] C_HLT = CTRL_W'(1) << B_HLT;
  localparam logic [CTRL_W-1:0] C_MI  = CTRL_W'(1) << B_MI;
  localparam logic [CTRL_W-1:0] C_RI  = CTRL_W'(1) << B_RI;
  localparam logic [CTRL_W-1:0] C_RO  = CTRL_W'(1) << B_RO;
  localparam logic [CTRL_W-1:0] C_IO  = CTRL_W'(1) << B_IO;
  localparam logic [CTRL_W-1:0] C_II  = CTRL_W'(1) << B_II;
  localparam logic [CTRL_W-1:0] C_AI  = CTRL_W'(1) << B_AI;
  localparam logic [CTRL_W-1:0] C_AO  = CTRL_W'(1) << B_AO;
  localparam logic [CTRL_W-1:0] C_EO  = CTRL_W'(1) << B_EO;
  localparam logic [CTRL_W-1:0] C_SU  = CTRL_W'(1) << B_SU;
  localparam logic [CTRL_W-1:0] C_BI  = CTRL_W'(1) << B_BI;
  localparam logic [CTRL_W-1:0] C_OI  = CTRL_W'(1) << B_OI;
  localparam logic [CTRL_W-1:0] C_CE  = CTRL_W'(1) << B_CE;
  localparam logic [CTRL_W-1:0] C_CO  = CTRL_W'(1) << B_CO;
  localparam logic [CTRL_W-1:0] C_J   = CTRL_W'(1) << B_J;
  localparam logic [CTRL_W-1:0] C_FI  = CTRL_W'(1) << B_FI;

  // Fetch: PC -> MAR, then RAM -> IR with PC increment.
  localparam logic [CTRL_W-1:0] FETCH0 = 16'h4004;
  localparam logic [CTRL_W-1:0] FETCH1 = 16'h1408;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

endpackage

// File: rtl/microcode_rom.sv
// microcode_rom: combinational microcode lookup.
//   opcode  in  4   instruction opcode (upper IR nibble)
//   step    in  3   T-state to decode (values above 4 decode to 0)
//   flag_c  in  1   carry flag, selects JC body
//   flag_z  in  1   zero flag, selects JZ body
//   word    out 16  control word for (opcode, step, flags)
module microcode_rom
  import ctrl_pkg::*;
(
  input  logic [3:0]        opcode,
  input  logic [STEP_W-1:0] step,
  input  logic              flag_c,
  input  logic              flag_z,
  output logic [CTRL_W-1:0] word
);

  always_comb begin
    word = '0;
    case (step)
      3'd0: word = FETCH0;
      3'd1: word = FETCH1;
      3'd2: begin
        case (opcode_e'(opcode))
          OP_LDA, OP_ADD, OP_SUB, OP_STA: word = C_IO | C_MI;
          OP_LDI: word = C_IO | C_AI;
          OP_JMP: word = C_IO | C_J;
          OP_JC:  word = flag_c ? (C_IO | C_J) : '0;
          OP_JZ:  word = flag_z ? (C_IO | C_J) : '0;
          OP_OUT: word = C_AO | C_OI;
          OP_HLT: word = C_HLT;
          default: word = '0;
        endcase
      end
      3'd3: begin
        case (opcode_e'(opcode))
          OP_LDA:         word = C_RO | C_AI;
          OP_ADD, OP_SUB: word = C_RO | C_BI;
          OP_STA:         word = C_AO | C_RI;
          default:        word = '0;
        endcase
      end
      3'd4: begin
        case (opcode_e'(opcode))
          OP_ADD:  word = C_EO | C_AI | C_FI;
          OP_SUB:  word = C_EO | C_AI | C_SU | C_FI;
          default: word = '0;
        endcase
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: T-state counter plus microcode decode for the 8-bit
// computer. Produces the control word for every bus-facing module and a
// registered halt back to the clock module.
//   clk     in  1   gated system clock, rising-edge active
//   rst_n   in  1   synchronous active-low reset
//   opcode  in  4   upper nibble of the instruction register
//   flag_c  in  1   carry flag
//   flag_z  in  1   zero flag
//   ctrl    out 16  control word (0 while in reset)
//   step    out 3   current T-state
//   hlt     out 1   registered halt, sticky until reset
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int STEPS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        opcode,
  input  logic              flag_c,
  input  logic              flag_z,
  output logic [CTRL_W-1:0] ctrl,
  output logic [STEP_W-1:0] step,
  output logic              hlt
);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

  logic [STEP_W-1:0] step_inc;
  logic [CTRL_W-1:0] word_cur;
  logic [CTRL_W-1:0] word_nxt;
  logic              early_end;

  assign step_inc = step + STEP_W'(1);

  microcode_rom u_rom_cur (
    .opcode (opcode),
    .step   (step),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .word   (word_cur)
  );

  // Looks one step ahead so a zero next word ends the instruction early.
  microcode_rom u_rom_nxt (
    .opcode (opcode),
    .step   (step_inc),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .word   (word_nxt)
  );

  // Opcode is only valid once II has loaded the IR, so fetch steps never
  // end early regardless of what the look-ahead ROM reports.
  assign early_end = (step == STEP_LAST) || (word_nxt == '0);

  assign ctrl = rst_n ? word_cur : '0;

  // A HLT word freezes the step on the same edge that raises hlt, so the
  // halted machine keeps presenting the HLT word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step <= '0;
      hlt  <= 1'b0;
    end else if (!hlt) begin
      if (ctrl[B_HLT]) begin
        hlt <= 1'b1;
      end else if (step < STEP_W'(2)) begin
        step <= step_inc;
      end else if (early_end) begin
        step <= '0;
      end else begin
        step <= step_inc;
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  opcode;
  logic        flag_c;
  logic        flag_z;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic        hlt;

  int n_cmp;
  int n_err;

  typedef struct {
    logic [2:0]  step;
    logic [15:0] ctrl;
    logic        hlt;
    string       tag;
  } exp_t;

  exp_t sb[$];

  control_sequencer #(.STEPS(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .opcode (opcode),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .ctrl   (ctrl),
    .step   (step),
    .hlt    (hlt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference instruction bodies (steps 2..), written from the opcode table.
  function automatic int body_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 2;
      4'h2, 4'h3: return 3;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [15:0] body_word(input logic [3:0] op, input logic fc,
                                            input logic fz, input int idx);
    case (op)
      4'h1: return (idx == 0) ? 16'h4800 : 16'h1200;
      4'h2: return (idx == 0) ? 16'h4800 : (idx == 1) ? 16'h1020 : 16'h0281;
      4'h3: return (idx == 0) ? 16'h4800 : (idx == 1) ? 16'h1020 : 16'h02C1;
      4'h4: return (idx == 0) ? 16'h4800 : 16'h2100;
      4'h5: return 16'h0A00;
      4'h6: return 16'h0802;
      4'h7: return fc ? 16'h0802 : 16'h0000;
      4'h8: return fz ? 16'h0802 : 16'h0000;
      4'hE: return 16'h0110;
      4'hF: return 16'h8000;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic push_exp(input logic [2:0] s, input logic [15:0] c, input logic h,
                          input string tag);
    exp_t e;
    e.step = s;
    e.ctrl = c;
    e.hlt  = h;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic push_instr(input logic [3:0] op, input logic fc, input logic fz,
                            input string name);
    push_exp(3'd0, 16'h4004, 1'b0, {name, "/s0"});
    push_exp(3'd1, 16'h1408, 1'b0, {name, "/s1"});
    for (int i = 0; i < body_len(op); i++)
      push_exp(3'(2 + i), body_word(op, fc, fz, i), 1'b0, $sformatf("%s/s%0d", name, 2 + i));
  endtask

  // Compare the current cycle against the head of the scoreboard, then advance.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "/step"}, 32'(step), 32'(e.step));
      chk({e.tag, "/ctrl"}, 32'(ctrl), 32'(e.ctrl));
      chk({e.tag, "/hlt"},  32'(hlt),  32'(e.hlt));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input logic [3:0] op, input logic fc, input logic fz,
                           input string name);
    opcode = op;
    flag_c = fc;
    flag_z = fz;
    push_instr(op, fc, fz, name);
    drain();
    chk({name, "/end_step"}, 32'(step), 32'd0);
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    opcode = 4'h0;
    flag_c = 1'b0;
    flag_z = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset/ctrl", 32'(ctrl), 32'h0000);
    chk("reset/step", 32'(step), 32'd0);
    chk("reset/hlt",  32'(hlt),  32'd0);
    rst_n = 1'b1;
    #1;
    chk("release/ctrl", 32'(ctrl), 32'h4004);

    run_instr(4'h1, 1'b0, 1'b0, "lda");
    run_instr(4'h2, 1'b0, 1'b0, "add");
    run_instr(4'h3, 1'b0, 1'b0, "sub");
    run_instr(4'h7, 1'b0, 1'b0, "jc_nt");
    run_instr(4'h7, 1'b1, 1'b0, "jc_t");
    run_instr(4'h8, 1'b0, 1'b0, "jz_nt");
    run_instr(4'h8, 1'b0, 1'b1, "jz_t");
    run_instr(4'h8, 1'b0, 1'b0, "jz_nt2");
    run_instr(4'h4, 1'b0, 1'b0, "sta");
    run_instr(4'h5, 1'b0, 1'b0, "ldi");
    run_instr(4'h6, 1'b0, 1'b0, "jmp");
    run_instr(4'hE, 1'b0, 1'b0, "out");
    run_instr(4'h0, 1'b0, 1'b0, "nop");
    run_instr(4'h9, 1'b0, 1'b0, "undef9");
    run_instr(4'hC, 1'b1, 1'b1, "undefC");

    // Reset in the middle of ADD, at step 3.
    opcode = 4'h2;
    push_exp(3'd0, 16'h4004, 1'b0, "addrst/s0");
    push_exp(3'd1, 16'h1408, 1'b0, "addrst/s1");
    push_exp(3'd2, 16'h4800, 1'b0, "addrst/s2");
    drain();
    chk("addrst/at_s3", 32'(step), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("addrst/ctrl_in_rst", 32'(ctrl), 32'h0000);
    @(posedge clk);
    #1;
    chk("addrst/step", 32'(step), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("addrst/refetch", 32'(ctrl), 32'h4004);
    run_instr(4'h2, 1'b0, 1'b0, "add2");

    // HLT: step freezes at 2, hlt set on the edge after the HLT word.
    opcode = 4'hF;
    push_instr(4'hF, 1'b0, 1'b0, "hlt");
    for (int i = 0; i < 6; i++)
      push_exp(3'd2, 16'h8000, 1'b1, $sformatf("halted%0d", i));
    drain();
    rst_n = 1'b0;
    #1;
    chk("hltrst/ctrl_in_rst", 32'(ctrl), 32'h0000);
    @(posedge clk);
    #1;
    chk("hltrst/step", 32'(step), 32'd0);
    chk("hltrst/hlt",  32'(hlt),  32'd0);
    rst_n = 1'b1;
    #1;
    run_instr(4'h1, 1'b0, 1'b0, "lda_after_hlt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Microinstruction sequencer for the 8-bit computer: counts T-states on the gated system clock `clk` and decodes the instruction register opcode and flags into the 16-bit control word that drives every bus-facing module. It sits directly downstream of the clock module, consuming `clk`. Its registered `hlt` output feeds back to the clock module's halt input, which stops the machine.

## Interface
Parameters:
- `STEPS`, 5: T-states per instruction; the step counter wraps at `STEPS-1`.

Ports:
- Clock and reset: one clock, `clk`; reset `rst_n` is synchronous and active-low.
- `clk`  in  1  system clock from the clock module; all state changes on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `opcode`  in  4  upper nibble of the instruction register.
- `flag_c`  in  1  carry flag from the flags register.
- `flag_z`  in  1  zero flag from the flags register.
- `ctrl`  out  16  control word; bit map below.
- `step`  out  3  current T-state, 0..4.
- `hlt`  out  1  registered halt; drives the clock module's halt input.

Control bit map (bit 15 down to bit 0):
- HLT, MI, RI, RO, IO, II, AI, AO, EO, SU, BI, OI, CE, CO, J, FI.

## Operation
- Opcodes and their step 2+ words:
  - 0 NOP: none.
  - 1 LDA: IO|MI, RO|AI.
  - 2 ADD: IO|MI, RO|BI, EO|AI|FI.
  - 3 SUB: IO|MI, RO|BI, EO|AI|SU|FI.
  - 4 STA: IO|MI, AO|RI.
  - 5 LDI: IO|AI.
  - 6 JMP: IO|J.
  - 7 JC: IO|J if `flag_c`, else 0.
  - 8 JZ: IO|J if `flag_z`, else 0.
  - E OUT: AO|OI.
  - F HLT: HLT.
  - Every other opcode decodes as NOP.
- Fetch steps, for every opcode:
  - Step 0: CO|MI = 0x4004.
  - Step 1: RO|II|CE = 0x1408.
- `ctrl` is the combinational microcode of the registered `step`, `opcode` and flags.
  - `ctrl` is forced to 0x0000 while `rst_n` = 0.
- Step advance at each rising edge, with `rst_n` = 1 and `hlt` = 0:
  - Steps 0 and 1 always advance by 1.
  - For step s ≥ 2: if s = 4, or the microcode word for step s+1 is 0x0000, then `step` <= 0; otherwise `step` <= s+1.
  - The early-end check is never evaluated at steps 0 and 1, because `opcode` is still stale until II takes effect at the end of step 1.
- Halt:
  - `hlt` sets on the edge where `ctrl[15]` = 1 and stays set until reset.
  - While `hlt` = 1, `step` holds its value and `ctrl` keeps presenting 0x8000.
- Reset: `rst_n` sampled low gives `step` = 0 and `hlt` = 0, regardless of the current step, including mid-instruction and while halted.

## Timing
- Reset values:
  - During reset: `step` = 0, `hlt` = 0, `ctrl` = 0x0000.
  - Immediately after release: `ctrl` = 0x4004.
- `step` and `hlt` are registered on the rising edge of `clk`.
- `ctrl` settles combinationally after each edge, or after any change to `opcode` or the flags.
  - Consumers sample it on the following rising edge.
- Instruction lengths in cycles:
  - 3: NOP, LDI, JMP, OUT, and JC/JZ whether taken or not taken.
  - 4: LDA, STA.
  - 5: ADD, SUB.
  - HLT never completes.
- Flags are evaluated live, with no latching.
- Simultaneous reset and HLT: reset wins.

## Structure
- Package `ctrl_pkg` holds:
  - the control bit index constants;
  - the opcode constants;
  - the fetch word constants 0x4004 and 0x1408.
- Sub-module `microcode_rom`: combinational (`opcode`, `step`, `flag_c`, `flag_z`) -> 16-bit word.
  - Instance 1 serves the current step and drives `ctrl`.
  - Instance 2 serves step+1 and feeds the early-end check.
- The top level holds the step register, the `hlt` register, and the reset gating of `ctrl`.

## Test plan
- Reset, then LDA (`opcode` = 1):
  - `ctrl` reads 0x0000 during reset.
  - Over the steps: 0x4004, 0x1408, 0x4800, 0x1200.
  - `step` returns to 0 after 4 edges.
- ADD (`opcode` = 2) then SUB (`opcode` = 3):
  - Step 4 reads 0x0281 for ADD and 0x02C1 for SUB.
  - Each instruction takes 5 edges.
- JC (`opcode` = 7):
  - With `flag_c` = 0: step 2 reads 0x0000 and the next edge gives `step` = 0.
  - With `flag_c` = 1: step 2 reads 0x0802.
  - Repeat for JZ (`opcode` = 8) with `flag_z`.
- HLT (`opcode` = F):
  - Step 2 reads 0x8000, and the next edge sets `hlt` = 1.
  - 5 further edges leave `step` = 2 and `hlt` = 1.
  - `rst_n` = 0 for one edge then gives `step` = 0, `hlt` = 0.
- Reset mid-ADD: `rst_n` = 0 at step 3 gives `step` = 0 on that edge, and the fetch restarts with 0x4004.
- Undefined opcode 0x9: runs as NOP, with step 2 = 0x0000 and a 3-cycle instruction.
